// File: rtl/strobed_sample_source.sv
// Strobed sample generator: phase accumulator feeding sine/triangle/sawtooth/square, one sample per rate_div clocks.
// Build option STROBE_TOGGLE_EN: strobe_out toggles per sample instead of pulsing.
module strobed_sample_source #(
  parameter int DATA_W  = 10,
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [CNT_W-1:0]   burst_len,
  output logic [DATA_W-1:0]  sample_out,
  output logic               strobe_out,
  output logic               busy,
  output logic [CNT_W-1:0]   sample_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [DIV_W-1:0]   rate_q, div_q, rate_d;
  logic [PHASE_W-1:0] phase_q, inc_q;
  logic [CNT_W-1:0]   burst_q, count_q, count_d;
  logic [DATA_W-1:0]  sample_q, wave_d;
  logic               strobe_q, busy_q;
  logic               due_s, last_s, strobe_hit_s, strobe_rest_s;

  // Quarter-wave table: round(511*sin(2*pi*a/256)), a = 0..64
  function automatic logic [8:0] sine_lut(input logic [6:0] a);
    case (a)
      7'd0:  sine_lut = 9'd0;   7'd1:  sine_lut = 9'd13;  7'd2:  sine_lut = 9'd25;  7'd3:  sine_lut = 9'd38;
      7'd4:  sine_lut = 9'd50;  7'd5:  sine_lut = 9'd63;  7'd6:  sine_lut = 9'd75;  7'd7:  sine_lut = 9'd87;
      7'd8:  sine_lut = 9'd100; 7'd9:  sine_lut = 9'd112; 7'd10: sine_lut = 9'd124; 7'd11: sine_lut = 9'd136;
      7'd12: sine_lut = 9'd148; 7'd13: sine_lut = 9'd160; 7'd14: sine_lut = 9'd172; 7'd15: sine_lut = 9'd184;
      7'd16: sine_lut = 9'd196; 7'd17: sine_lut = 9'd207; 7'd18: sine_lut = 9'd218; 7'd19: sine_lut = 9'd230;
      7'd20: sine_lut = 9'd241; 7'd21: sine_lut = 9'd252; 7'd22: sine_lut = 9'd263; 7'd23: sine_lut = 9'd273;
      7'd24: sine_lut = 9'd284; 7'd25: sine_lut = 9'd294; 7'd26: sine_lut = 9'd304; 7'd27: sine_lut = 9'd314;
      7'd28: sine_lut = 9'd324; 7'd29: sine_lut = 9'd334; 7'd30: sine_lut = 9'd343; 7'd31: sine_lut = 9'd352;
      7'd32: sine_lut = 9'd361; 7'd33: sine_lut = 9'd370; 7'd34: sine_lut = 9'd379; 7'd35: sine_lut = 9'd387;
      7'd36: sine_lut = 9'd395; 7'd37: sine_lut = 9'd403; 7'd38: sine_lut = 9'd410; 7'd39: sine_lut = 9'd418;
      7'd40: sine_lut = 9'd425; 7'd41: sine_lut = 9'd432; 7'd42: sine_lut = 9'd438; 7'd43: sine_lut = 9'd445;
      7'd44: sine_lut = 9'd451; 7'd45: sine_lut = 9'd456; 7'd46: sine_lut = 9'd462; 7'd47: sine_lut = 9'd467;
      7'd48: sine_lut = 9'd472; 7'd49: sine_lut = 9'd477; 7'd50: sine_lut = 9'd481; 7'd51: sine_lut = 9'd485;
      7'd52: sine_lut = 9'd489; 7'd53: sine_lut = 9'd492; 7'd54: sine_lut = 9'd496; 7'd55: sine_lut = 9'd499;
      7'd56: sine_lut = 9'd501; 7'd57: sine_lut = 9'd503; 7'd58: sine_lut = 9'd505; 7'd59: sine_lut = 9'd507;
      7'd60: sine_lut = 9'd509; 7'd61: sine_lut = 9'd510; 7'd62: sine_lut = 9'd510; 7'd63: sine_lut = 9'd511;
      7'd64: sine_lut = 9'd511;
      default: sine_lut = 9'd0;
    endcase
  endfunction

  function automatic logic [9:0] wave(input logic [1:0] m, input logic [PHASE_W-1:0] ph);
    logic [7:0] k;
    logic [8:0] p;
    logic [7:0] idx;
    logic [9:0] l;
    k = ph[PHASE_W-1 -: 8];
    p = ph[PHASE_W-2 -: 9];
    if (k < 8'd64)       idx = k;
    else if (k < 8'd128) idx = 8'd128 - k;
    else if (k < 8'd192) idx = k - 8'd128;
    else                 idx = 8'd0 - k;
    l = {1'b0, sine_lut(idx[6:0])};
    case (m)
      2'b00:   wave = k[7] ? (10'd512 - l) : (10'd512 + l);
      2'b01:   wave = ph[PHASE_W-1] ? {~p, 1'b1} : {p, 1'b0};
      2'b10:   wave = ph[PHASE_W-1 -: 10];
      default: wave = ph[PHASE_W-1] ? 10'd1023 : 10'd0;
    endcase
  endfunction

  always_comb begin
    rate_d  = (rate_div == '0) ? DIV_ONE : rate_div;
    due_s   = (div_q == rate_q - DIV_ONE);
    count_d = count_q + CNT_ONE;
    last_s  = (burst_q != '0) && (count_d == burst_q);
    wave_d  = wave(mode_q, phase_q);
`ifdef STROBE_TOGGLE_EN
    strobe_hit_s  = ~strobe_q;
    strobe_rest_s = strobe_q;
`else
    strobe_hit_s  = 1'b1;
    strobe_rest_s = 1'b0;
`endif
  end

  // Strobe falls back to its rest value on every non-emitting cycle, including frozen ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      rate_q   <= DIV_ONE;
      div_q    <= '0;
      phase_q  <= '0;
      inc_q    <= '0;
      burst_q  <= '0;
      count_q  <= '0;
      sample_q <= DATA_W'(512);
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= strobe_rest_s;
      if (ena) begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              mode_q  <= mode;
              rate_q  <= rate_d;
              inc_q   <= phase_inc;
              burst_q <= burst_len;
              div_q   <= '0;
              phase_q <= '0;
              count_q <= '0;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (due_s) begin
              sample_q <= wave_d;
              strobe_q <= strobe_hit_s;
              phase_q  <= phase_q + inc_q;
              div_q    <= '0;
              count_q  <= count_d;
              if (last_s) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              div_q <= div_q + DIV_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sample_out   = sample_q;
  assign strobe_out   = strobe_q;
  assign busy         = busy_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_strobed_sample_source.sv
// Directed bench for strobed_sample_source; works in pulse and STROBE_TOGGLE_EN builds.
module tb_strobed_sample_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] rate_div = 16'd0;
  logic [15:0] phase_inc = 16'd0;
  logic [15:0] burst_len = 16'd0;
  logic [9:0]  sample_out;
  logic        strobe_out;
  logic        busy;
  logic [15:0] sample_count;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  logic ev = 1'b0;
  logic prev_strb = 1'b0;

  strobed_sample_source dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .rate_div(rate_div), .phase_inc(phase_inc), .burst_len(burst_len),
    .sample_out(sample_out), .strobe_out(strobe_out), .busy(busy), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
`ifdef STROBE_TOGGLE_EN
    ev = (strobe_out != prev_strb);
`else
    ev = strobe_out;
`endif
    prev_strb = strobe_out;
  endtask

  task automatic wait_strobe(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ev && n < max);
    if (!ev) begin
      total_cnt++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", max);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] rd, input logic [15:0] inc, input logic [15:0] bl);
    mode = m; rate_div = rd; phase_inc = inc; burst_len = bl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (sample_out !== 10'd512) $display("FAIL rst_sample: got %0d want 512", sample_out); else pass_cnt++;
    total_cnt++; if (strobe_out !== 1'b0) $display("FAIL rst_strobe: got %0b want 0", strobe_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (sample_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", sample_count); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sine();
    int n;
    logic [9:0] exp_s [3];
    exp_s = '{10'd512, 10'd525, 10'd537};
    launch(2'b00, 16'd50, 16'h0100, 16'd0);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(60, n);
      total_cnt++; if (n != 50) $display("FAIL sine_period%0d: got %0d want 50", i, n); else pass_cnt++;
      total_cnt++; if (sample_out !== exp_s[i]) $display("FAIL sine_sample%0d: got %0d want %0d", i, sample_out, exp_s[i]); else pass_cnt++;
    end
    total_cnt++; if (busy !== 1'b1) $display("FAIL sine_busy: got %0b want 1", busy); else pass_cnt++;
    total_cnt++; if (sample_count !== 16'd3) $display("FAIL sine_count: got %0d want 3", sample_count); else pass_cnt++;
    halt();
    total_cnt++; if (busy !== 1'b0) $display("FAIL sine_stop_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (sample_out !== 10'd537) $display("FAIL sine_hold: got %0d want 537", sample_out); else pass_cnt++;
    // one sample per clock so k walks 0..192
    launch(2'b00, 16'd1, 16'h0100, 16'd0);
    for (int i = 0; i <= 192; i++) begin
      wait_strobe(4, n);
      if (i == 32) begin
        total_cnt++; if (sample_out !== 10'd873) $display("FAIL sine_k32: got %0d want 873", sample_out); else pass_cnt++;
      end else if (i == 64) begin
        total_cnt++; if (sample_out !== 10'd1023) $display("FAIL sine_k64: got %0d want 1023", sample_out); else pass_cnt++;
      end else if (i == 128) begin
        total_cnt++; if (sample_out !== 10'd512) $display("FAIL sine_k128: got %0d want 512", sample_out); else pass_cnt++;
      end else if (i == 192) begin
        total_cnt++; if (sample_out !== 10'd1) $display("FAIL sine_k192: got %0d want 1", sample_out); else pass_cnt++;
      end
    end
    halt();
  endtask

  task automatic test_tri_square();
    int n;
    logic [9:0] exp_t [4];
    exp_t = '{10'd0, 10'd512, 10'd1023, 10'd511};
    launch(2'b01, 16'd2, 16'h4000, 16'd4);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(5, n);
      total_cnt++; if (sample_out !== exp_t[i]) $display("FAIL tri_sample%0d: got %0d want %0d", i, sample_out, exp_t[i]); else pass_cnt++;
    end
    launch(2'b11, 16'd1, 16'h8000, 16'd2);
    wait_strobe(5, n);
    total_cnt++; if (sample_out !== 10'd0) $display("FAIL sq_low: got %0d want 0", sample_out); else pass_cnt++;
    wait_strobe(5, n);
    total_cnt++; if (sample_out !== 10'd1023) $display("FAIL sq_high: got %0d want 1023", sample_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sq_burst_busy: got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_burst();
    int n;
    int extra;
    launch(2'b10, 16'd3, 16'h4000, 16'd4);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(6, n);
      total_cnt++; if (n != 3) $display("FAIL burst_period%0d: got %0d want 3", i, n); else pass_cnt++;
      total_cnt++; if (sample_out !== 10'(i * 256)) $display("FAIL burst_sample%0d: got %0d want %0d", i, sample_out, i * 256); else pass_cnt++;
      total_cnt++; if (busy !== (i < 3)) $display("FAIL burst_busy%0d: got %0b want %0b", i, busy, (i < 3)); else pass_cnt++;
    end
    total_cnt++; if (sample_count !== 16'd4) $display("FAIL burst_count: got %0d want 4", sample_count); else pass_cnt++;
    extra = 0;
    repeat (10) begin tick(); if (ev) extra++; end
    total_cnt++; if (extra != 0) $display("FAIL burst_extra: got %0d strobes want 0", extra); else pass_cnt++;
  endtask

  task automatic test_rate01();
    int n;
    for (int r = 0; r < 2; r++) begin
      launch(2'b10, 16'(r), 16'h0040, 16'd0);
      for (int i = 0; i < 2; i++) begin
        wait_strobe(3, n);
        total_cnt++; if (n != 1) $display("FAIL rate%0d_period%0d: got %0d want 1", r, i, n); else pass_cnt++;
        total_cnt++; if (sample_out !== 10'(i)) $display("FAIL rate%0d_sample%0d: got %0d want %0d", r, i, sample_out, i); else pass_cnt++;
      end
      halt();
      total_cnt++; if (ev !== 1'b0) $display("FAIL rate%0d_stop_strobe: got %0b want 0", r, ev); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rate%0d_stop_busy: got %0b want 0", r, busy); else pass_cnt++;
      total_cnt++; if (sample_out !== 10'd1) $display("FAIL rate%0d_stop_hold: got %0d want 1", r, sample_out); else pass_cnt++;
    end
    launch(2'b10, 16'd5, 16'h0040, 16'd0);
    wait_strobe(8, n);
    repeat (4) tick();
    halt();
    total_cnt++; if (ev !== 1'b0) $display("FAIL due_stop_strobe: got %0b want 0", ev); else pass_cnt++;
    total_cnt++; if (sample_count !== 16'd1) $display("FAIL due_stop_count: got %0d want 1", sample_count); else pass_cnt++;
  endtask

  task automatic test_start_stop();
    int n;
    int extra;
    start = 1'b1; stop = 1'b1; mode = 2'b10; rate_div = 16'd1; phase_inc = 16'h0040; burst_len = 16'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL startstop_busy: got %0b want 0", busy); else pass_cnt++;
    extra = 0;
    repeat (4) begin tick(); if (ev) extra++; end
    total_cnt++; if (extra != 0) $display("FAIL startstop_strobes: got %0d want 0", extra); else pass_cnt++;
    launch(2'b10, 16'd4, 16'h1000, 16'd0);
    wait_strobe(8, n);
    total_cnt++; if (sample_out !== 10'd0) $display("FAIL rerun_s0: got %0d want 0", sample_out); else pass_cnt++;
    launch(2'b11, 16'd2, 16'h4000, 16'd1);
    wait_strobe(8, n);
    total_cnt++; if (n != 3) $display("FAIL rerun_gap: got %0d want 3", n); else pass_cnt++;
    total_cnt++; if (sample_out !== 10'd64) $display("FAIL rerun_s1: got %0d want 64", sample_out); else pass_cnt++;
    wait_strobe(8, n);
    total_cnt++; if (n != 4) $display("FAIL rerun_period: got %0d want 4", n); else pass_cnt++;
    total_cnt++; if (sample_out !== 10'd128) $display("FAIL rerun_s2: got %0d want 128", sample_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rerun_busy: got %0b want 1", busy); else pass_cnt++;
    halt();
  endtask

  task automatic test_freeze_rst();
    int n;
    int extra;
    launch(2'b10, 16'd10, 16'h1000, 16'd0);
    wait_strobe(15, n);
    total_cnt++; if (n != 10) $display("FAIL frz_first: got %0d want 10", n); else pass_cnt++;
    repeat (3) tick();
    ena = 1'b0;
    extra = 0;
    repeat (7) begin tick(); if (ev) extra++; end
    ena = 1'b1;
    total_cnt++; if (extra != 0) $display("FAIL frz_strobes: got %0d want 0", extra); else pass_cnt++;
    wait_strobe(20, n);
    total_cnt++; if (n != 7) $display("FAIL frz_delay: got %0d want 7", n); else pass_cnt++;
    total_cnt++; if (sample_out !== 10'd64) $display("FAIL frz_sample: got %0d want 64", sample_out); else pass_cnt++;
    total_cnt++; if (sample_count !== 16'd2) $display("FAIL frz_count: got %0d want 2", sample_count); else pass_cnt++;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (sample_out !== 10'd512) $display("FAIL midrst_sample: got %0d want 512", sample_out); else pass_cnt++;
    total_cnt++; if (strobe_out !== 1'b0) $display("FAIL midrst_strobe: got %0b want 0", strobe_out); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (sample_count !== 16'd0) $display("FAIL midrst_count: got %0d want 0", sample_count); else pass_cnt++;
    rst = 1'b0;
    tick();
    launch(2'b10, 16'd10, 16'h1000, 16'd0);
    wait_strobe(15, n);
    total_cnt++; if (n != 10) $display("FAIL postrst_lat: got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (sample_out !== 10'd0) $display("FAIL postrst_sample: got %0d want 0", sample_out); else pass_cnt++;
    halt();
  endtask

  initial begin
    test_reset();
    test_sine();
    test_tri_square();
    test_burst();
    test_rate01();
    test_start_stop();
    test_freeze_rst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
